bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
- Streaming FIFO controller that drives the write and read ports of the team's simple dual-port block RAM (bram_dual_port, RAM_WIDTH x RAM_DEPTH).
- Accepts words on a valid/ready slave stream and issues BRAM writes.
- Prefetches BRAM reads to hide the RAM's 1-cycle registered read latency.
- Presents first-word-fall-through data on a valid/ready master stream at full throughput (one word per clock in and out).

Parameters:
- RAM_WIDTH, 64, data word width; must equal the BRAM's RAM_WIDTH.
- RAM_DEPTH, 512, BRAM depth in words; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock for all logic; same clock as the BRAM.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  RAM_WIDTH  upstream word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  RAM_WIDTH  output word; head of the output buffer.
- wr_ena  out  1  BRAM write enable.
- addra  out  $clog2(RAM_DEPTH)  BRAM write address.
- dina  out  RAM_WIDTH  BRAM write data.
- rd_enb  out  1  BRAM read enable.
- addrb  out  $clog2(RAM_DEPTH)  BRAM read address.
- doutb  in  RAM_WIDTH  BRAM registered read data; valid the cycle after rd_enb.
- level  out  $clog2(RAM_DEPTH+2)+1  total words held: mem_cnt + rd_inflight + ob_cnt.

Behaviour:
- Reset: the async assert of rst clears wr_ptr, rd_ptr, mem_cnt, rd_inflight, ob_cnt and both output-buffer entries; m_data=0, m_valid=0, level=0, s_ready=1.
  - Reset mid-operation discards all contents. BRAM contents are left as-is and ignored.
- Write side (combinational on state):
  - s_ready = (mem_cnt < RAM_DEPTH).
  - push = s_valid & s_ready.
  - wr_ena = push, addra = wr_ptr, dina = s_data.
  - wr_ptr increments on push and wraps from RAM_DEPTH-1 to 0.
- Read issue (combinational):
  - pop = m_valid & m_ready.
  - issue = (mem_cnt > 0) & ((ob_cnt + rd_inflight - pop) < 2).
  - rd_enb = issue, addrb = rd_ptr. rd_ptr increments on issue and wraps.
- mem_cnt (0..RAM_DEPTH) updates next edge by +push -issue; simultaneous push and issue leaves it unchanged.
- rd_inflight register is set to issue each cycle. When rd_inflight=1, doutb is written into the output buffer at the end of that cycle.
- Output buffer:
  - 2-entry FIFO of registers; ob_cnt is 0..2. m_valid = (ob_cnt != 0); m_data = head entry.
  - Capture and pop may happen in the same cycle: the head advances and the new word enters the tail.
  - Overflow is impossible by construction of the issue rule; verification asserts ob_cnt <= 2.
- Collision: addra == addrb while wr_ena & rd_enb never occurs, because a read needs mem_cnt > 0 and a write needs mem_cnt < RAM_DEPTH. Verification asserts this.
- Latency:
  - A word pushed in cycle N into an idle, empty FIFO is written at edge N, so mem_cnt=1 in N+1.
  - rd_enb is issued in N+1; doutb is valid in N+2; m_valid=1 in N+3.
  - Under continuous push and m_ready=1, throughput is 1 word/cycle in steady state.
- Full: mem_cnt == RAM_DEPTH gives s_ready=0. Maximum level = RAM_DEPTH + 2.
  - A pop from full frees BRAM space only once a read is issued. s_ready rises the cycle after that issue.
- Empty: level=0 gives m_valid=0 and rd_enb=0.
- m_valid, once asserted, stays high with m_data stable until pop.
- Ordering is strict FIFO across the BRAM and the output buffer.

Test Plan:
- Reset then idle -> m_valid=0, s_ready=1, level=0, wr_ena=0, rd_enb=0 for 20 cycles.
- Push single word 0xA5A5 at cycle 10 with m_ready=1 -> wr_ena=1, addra=0 at cycle 10; rd_enb=1, addrb=0 at cycle 11; m_valid=1, m_data=0xA5A5 at cycle 13; level returns to 0 after the pop.
- Fill with m_ready=0 and data 0..513 offered (DEPTH=512) -> 514 words accepted (512 in BRAM plus 2 in the output buffer, after prefetch); s_ready=0 at level=514; then drain with m_ready=1 -> output sequence 0..513 in order, no gaps after the first word.
- Streaming with s_valid=1 and m_ready=1 for 2000 incrementing words -> after the 3-cycle fill, one output per cycle, correct order, pointers wrap past 511 with no loss.
- Random s_valid/m_ready (50% each), 10k words -> scoreboard match, no wr/rd address collision, ob_cnt <= 2, level always equals pushes minus pops.
- Assert rst for 1 cycle with level=300 -> next cycle level=0, m_valid=0, s_ready=1; a subsequent push of 0x1234 emerges as the first output.

Source files
------------

// File: rtl/bram_fifo_if.sv
// Stream bundle for bram_fifo_ctrl.
// Slave side is the controller; master side is the producer/consumer.
interface bram_fifo_if #(
  parameter int RAM_WIDTH = 64
);
  logic                 s_valid;
  logic                 s_ready;
  logic [RAM_WIDTH-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [RAM_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// FWFT stream FIFO built on a simple dual-port BRAM.
// Reads are prefetched into a 2-entry register buffer to hide read latency.
module bram_fifo_ctrl #(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 512,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int LW = $clog2(RAM_DEPTH + 2) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_fifo_if.slave           st,
  output logic                 wr_ena,
  output logic [AW-1:0]        addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 rd_enb,
  output logic [AW-1:0]        addrb,
  input  logic [RAM_WIDTH-1:0] doutb,
  output logic [LW-1:0]        level
);
  localparam int CW = $clog2(RAM_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAM_DEPTH);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        mem_cnt;
  logic                 rd_inflight;
  logic [1:0]           ob_cnt;
  logic [RAM_WIDTH-1:0] ob0;
  logic [RAM_WIDTH-1:0] ob1;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [2:0]           occ;

  assign st.s_ready = (mem_cnt < FULL);
  assign st.m_valid = (ob_cnt != 2'd0);
  assign st.m_data  = ob0;

  assign push   = st.s_valid & st.s_ready;
  assign pop    = st.m_valid & st.m_ready;
  assign wr_ena = push;
  assign addra  = wr_ptr;
  assign dina   = st.s_data;
  assign rd_enb = issue;
  assign addrb  = rd_ptr;

  assign level = LW'(mem_cnt) + LW'(rd_inflight) + LW'(ob_cnt);

  // Issue a read only if the buffer will have room when the data lands
  always_comb begin
    occ   = {1'b0, ob_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    issue = (mem_cnt != '0) && (occ < 3'd2);
  end

  // BRAM pointers, occupancy and read-in-flight tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= issue;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // Output buffer: ob0 is the head, ob1 the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      unique case ({rd_inflight, pop})
        2'b11: begin
          if (ob_cnt == 2'd2) begin
            ob0 <= ob1;
            ob1 <= doutb;
          end else begin
            ob0 <= doutb;
          end
        end
        2'b01: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b10: begin
          if (ob_cnt == 2'd0)
            ob0 <= doutb;
          else
            ob1 <= doutb;
          ob_cnt <= ob_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed + random bench for bram_fifo_ctrl.
// Includes a behavioural registered-read dual-port RAM.
module tb_bram_fifo_ctrl;
  localparam int W  = 64;
  localparam int D  = 512;
  localparam int AW = 9;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bram_fifo_if #(.RAM_WIDTH(W)) st ();

  logic          wr_ena;
  logic          rd_enb;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic [W-1:0]  dina;
  logic [W-1:0]  doutb;
  logic [LW-1:0] level;

  bram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .wr_ena (wr_ena),
    .addra  (addra),
    .dina   (dina),
    .rd_enb (rd_enb),
    .addrb  (addrb),
    .doutb  (doutb),
    .level  (level)
  );

  logic [W-1:0] mem [D];
  always_ff @(posedge clk) begin
    if (wr_ena) mem[addra] <= dina;
    if (rd_enb) doutb <= mem[addrb];
  end

  int           n_assert = 0;
  int           n_fail = 0;
  logic [W-1:0] sb[$];
  int           exp_wa = 0;
  int           exp_ra = 0;
  bit           did_push;
  bit           did_pop;
  bit           seen_pop = 0;
  int           gaps = 0;
  bit           prev_hold = 0;
  logic [W-1:0] prev_data;
  logic [W-1:0] last_pop;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit p;
    did_push = 0;
    did_pop  = 0;
    chk("level", 64'(level), 64'(sb.size()));
    chk("ob_cnt_le2", 64'(dut.ob_cnt <= 2'd2), 64'd1);
    chk("collision", 64'(wr_ena && rd_enb && addra == addrb), 64'd0);
    if (prev_hold) begin
      chk("hold_valid", 64'(st.m_valid), 64'd1);
      chk("hold_data", st.m_data, prev_data);
    end
    if (st.m_valid && st.m_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        last_pop = st.m_data;
        chk("m_data", st.m_data, sb.pop_front());
        did_pop  = 1;
        seen_pop = 1;
      end
    end else if (seen_pop && sb.size() != 0 && st.m_ready) begin
      gaps++;
    end
    p = st.s_valid && st.s_ready;
    chk("wr_ena", 64'(wr_ena), 64'(p));
    if (p) begin
      chk("addra", 64'(addra), 64'(exp_wa));
      chk("dina", dina, st.s_data);
      sb.push_back(st.s_data);
      exp_wa   = (exp_wa + 1) % D;
      did_push = 1;
    end
    if (rd_enb) begin
      chk("addrb", 64'(addrb), 64'(exp_ra));
      exp_ra = (exp_ra + 1) % D;
    end
    prev_hold = st.m_valid && !st.m_ready;
    prev_data = st.m_data;
  endtask

  task automatic tick();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  initial begin
    int nv;
    int sent;
    st.s_valid = 1'b0;
    st.s_data  = '0;
    st.m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", 64'(st.m_valid), 64'd0);
    chk("rst_s_ready", 64'(st.s_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_m_data", st.m_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      #1;
      chk("idle_m_valid", 64'(st.m_valid), 64'd0);
      chk("idle_s_ready", 64'(st.s_ready), 64'd1);
      chk("idle_rd_enb", 64'(rd_enb), 64'd0);
      tick();
    end

    st.s_valid = 1'b1;
    st.s_data  = 64'hA5A5;
    st.m_ready = 1'b1;
    #1;
    chk("one_wr_ena", 64'(wr_ena), 64'd1);
    chk("one_addra", 64'(addra), 64'd0);
    tick();
    st.s_valid = 1'b0;
    #1;
    chk("one_rd_enb", 64'(rd_enb), 64'd1);
    chk("one_addrb", 64'(addrb), 64'd0);
    tick();
    #1;
    chk("one_n2_valid", 64'(st.m_valid), 64'd0);
    tick();
    #1;
    chk("one_n3_valid", 64'(st.m_valid), 64'd1);
    chk("one_n3_data", st.m_data, 64'hA5A5);
    tick();
    #1;
    chk("one_level0", 64'(level), 64'd0);
    tick();

    st.m_ready = 1'b0;
    nv = 0;
    for (int c = 0; c < 700 && level != LW'(514); c++) begin
      st.s_valid = 1'b1;
      st.s_data  = 64'(nv);
      tick();
      if (did_push) nv++;
    end
    chk("fill_level", 64'(level), 64'd514);
    chk("fill_count", 64'(nv), 64'd514);
    #1;
    chk("fill_s_ready", 64'(st.s_ready), 64'd0);
    chk("fill_head", st.m_data, 64'd0);
    for (int i = 0; i < 3; i++) tick();
    st.s_valid = 1'b0;
    st.m_ready = 1'b1;
    seen_pop   = 0;
    gaps       = 0;
    #1;
    chk("drain_rd_enb", 64'(rd_enb), 64'd1);
    chk("drain_s_ready0", 64'(st.s_ready), 64'd0);
    tick();
    #1;
    chk("drain_s_ready1", 64'(st.s_ready), 64'd1);
    for (int c = 0; c < 700 && sb.size() != 0; c++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_gaps", 64'(gaps), 64'd0);
    for (int i = 0; i < 3; i++) tick();

    seen_pop   = 0;
    gaps       = 0;
    st.m_ready = 1'b1;
    sent       = 0;
    for (int c = 0; c < 2500 && sent < 2000; c++) begin
      st.s_valid = 1'b1;
      st.s_data  = 64'h1_0000_0000 + 64'(sent);
      tick();
      if (did_push) sent++;
    end
    st.s_valid = 1'b0;
    for (int c = 0; c < 50 && sb.size() != 0; c++) tick();
    chk("stream_sent", 64'(sent), 64'd2000);
    chk("stream_empty", 64'(sb.size()), 64'd0);
    chk("stream_gaps", 64'(gaps), 64'd0);

    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      st.s_valid = 1'($urandom_range(0, 1));
      st.s_data  = {$urandom, $urandom};
      st.m_ready = 1'($urandom_range(0, 1));
      tick();
      if (did_push) sent++;
    end
    st.s_valid = 1'b0;
    st.m_ready = 1'b1;
    for (int c = 0; c < 1000 && sb.size() != 0; c++) tick();
    chk("rand_sent", 64'(sent), 64'd10000);
    chk("rand_empty", 64'(sb.size()), 64'd0);

    st.m_ready = 1'b0;
    for (int c = 0; c < 400 && level != LW'(300); c++) begin
      st.s_valid = 1'b1;
      st.s_data  = {$urandom, $urandom};
      tick();
    end
    chk("pre_rst_level", 64'(level), 64'd300);
    st.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_level", 64'(level), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_wa    = 0;
    exp_ra    = 0;
    prev_hold = 0;
    #1;
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_m_valid", 64'(st.m_valid), 64'd0);
    chk("post_rst_s_ready", 64'(st.s_ready), 64'd1);
    st.s_valid = 1'b1;
    st.s_data  = 64'h1234;
    st.m_ready = 1'b1;
    tick();
    st.s_valid = 1'b0;
    did_pop    = 0;
    for (int c = 0; c < 10 && !did_pop; c++) tick();
    chk("post_rst_popped", 64'(did_pop), 64'd1);
    chk("post_rst_first", last_pop, 64'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
